// File: rtl/battle_pkg.sv
// -----------------------------------------------------------------------------
// battle_pkg
// Shared encodings for the battle controller: keyboard key codes, page codes,
// player instruction opcodes and movement directions. Also provides a helper
// that maps a movement key to a direction.
// -----------------------------------------------------------------------------
package battle_pkg;

    // Keyboard key codes as delivered on the keyboard input.
    typedef enum logic [3:0] {
        KEY_NONE  = 4'd0,
        KEY_W     = 4'd1,
        KEY_S     = 4'd2,
        KEY_A     = 4'd3,
        KEY_D     = 4'd4,
        KEY_J     = 4'd5,
        KEY_K     = 4'd6,
        KEY_L     = 4'd7,
        KEY_SPACE = 4'd8
    } key_e;

    // Top-level page codes, upper nibble of the state output.
    typedef enum logic [3:0] {
        PAGE_MENU   = 4'h1,
        PAGE_DODGE  = 4'h9,
        PAGE_ATTACK = 4'hA,
        PAGE_ACTION = 4'hB
    } page_e;

    // Player instruction opcodes, upper nibble of player_instr.
    typedef enum logic [3:0] {
        OP_HPY = 4'd1,
        OP_DPY = 4'd2,
        OP_IDG = 4'd3,
        OP_SDG = 4'd4,
        OP_MOV = 4'd5,
        OP_SHP = 4'd6
    } opcode_e;

    // Movement directions carried in the second nibble of a MOV instruction.
    typedef enum logic [3:0] {
        DIR_UP    = 4'd0,
        DIR_RIGHT = 4'd1,
        DIR_DOWN  = 4'd2,
        DIR_LEFT  = 4'd3
    } dir_e;

    // Every page currently uses substage 0.
    localparam logic [3:0] SUBSTAGE_0 = 4'h0;

    typedef struct packed {
        logic valid;
        dir_e dir;
    } move_t;

    // Map a held key to a movement; valid is low for non-movement keys.
    function automatic move_t key_to_move(input logic [3:0] key);
        move_t mv;
        mv.valid = 1'b1;
        mv.dir   = DIR_UP;
        case (key)
            KEY_W:   mv.dir = DIR_UP;
            KEY_D:   mv.dir = DIR_RIGHT;
            KEY_S:   mv.dir = DIR_DOWN;
            KEY_A:   mv.dir = DIR_LEFT;
            default: mv.valid = 1'b0;
        endcase
        return mv;
    endfunction

endpackage

// File: rtl/key_edge.sv
// -----------------------------------------------------------------------------
// key_edge
// Registers the previous keyboard code and flags a press: a nonzero key code
// that differs from last cycle's code. Holding a key therefore yields a single
// press strobe; switching directly between two keys yields a new strobe.
//
// Ports
//   clk      input   system clock
//   rst_n    input   asynchronous active-low reset (clears key history)
//   key_i    input   current keyboard code
//   press_o  output  press strobe for the current key_i (combinational)
// -----------------------------------------------------------------------------
module key_edge
    import battle_pkg::*;
(
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] key_i,
    output logic       press_o
);

    logic [3:0] key_q;

    // NOTE: sequential state is written with non-blocking assignments so every
    // register samples pre-edge values regardless of process ordering.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            key_q <= KEY_NONE;
        end else begin
            key_q <= key_i;
        end
    end

    assign press_o = (key_i != KEY_NONE) && (key_i != key_q);

endmodule

// File: rtl/battle_controller.sv
// -----------------------------------------------------------------------------
// battle_controller
// Game flow controller for a turn-based bullet-dodge battle. The page FSM walks
// MENU -> DODGE -> ACTION -> (ATTACK | DODGE | MENU) and tracks player HP and
// accumulated monster damage. All outputs are registered.
//
// Ports
//   clk           input   system clock
//   rst_n         input   asynchronous active-low reset
//   keyboard      input   key code (0 none, W S A D J K L SPACE = 1..8)
//   tick          input   one-clk frame pulse, paces the DODGE phase
//   hit           input   bullet struck the player this cycle
//   hit_dmg       input   damage of that hit
//   atk_pass      input   attack minigame finished
//   atk_dmg       input   damage dealt to the monster
//   state         output  {page, substage}
//   player_instr  output  {opcode, dir, 0, 0}; MOV while moving in DODGE
//   is_move       output  player_instr carries a MOV
//   mon_hp        output  accumulated monster damage
//   player_hp     output  current player HP
//   win           output  one-cycle victory pulse
//   lose          output  one-cycle death pulse
// -----------------------------------------------------------------------------
module battle_controller
    import battle_pkg::*;
#(
    parameter int HP_W           = 8,
    parameter int MON_HP_MAX     = 100,
    parameter int PLAYER_HP_INIT = 20,
    parameter int HEAL_AMT       = 5,
    parameter int DODGE_TICKS    = 60
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic [3:0]      keyboard,
    input  logic            tick,
    input  logic            hit,
    input  logic [HP_W-1:0] hit_dmg,
    input  logic            atk_pass,
    input  logic [HP_W-1:0] atk_dmg,
    output logic [7:0]      state,
    output logic [15:0]     player_instr,
    output logic            is_move,
    output logic [HP_W-1:0] mon_hp,
    output logic [HP_W-1:0] player_hp,
    output logic            win,
    output logic            lose
);

    localparam int              CNT_W      = $clog2(DODGE_TICKS + 1);
    localparam logic [CNT_W-1:0] CNT_LAST  = CNT_W'(DODGE_TICKS - 1);
    localparam logic [HP_W-1:0] MON_MAX_C  = HP_W'(MON_HP_MAX);
    localparam logic [HP_W-1:0] HP_INIT_C  = HP_W'(PLAYER_HP_INIT);
    localparam logic [HP_W-1:0] HEAL_C     = HP_W'(HEAL_AMT);

    // -------------------------------------------------------------------------
    // Key press detection
    // -------------------------------------------------------------------------
    logic press;

    key_edge u_key_edge (
        .clk     (clk),
        .rst_n   (rst_n),
        .key_i   (keyboard),
        .press_o (press)
    );

    // -------------------------------------------------------------------------
    // Saturating arithmetic helpers
    // -------------------------------------------------------------------------
    function automatic logic [HP_W-1:0] sat_sub(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        return (a >= b) ? (a - b) : '0;
    endfunction

    function automatic logic [HP_W-1:0] sat_add(input logic [HP_W-1:0] a,
                                                input logic [HP_W-1:0] b);
        logic [HP_W:0] wide;
        wide = {1'b0, a} + {1'b0, b};
        return wide[HP_W] ? '1 : wide[HP_W-1:0];
    endfunction

    // Heal never lifts HP above the starting value.
    function automatic logic [HP_W-1:0] heal(input logic [HP_W-1:0] hp);
        logic [HP_W:0] wide;
        wide = {1'b0, hp} + {1'b0, HEAL_C};
        return (wide > {1'b0, HP_INIT_C}) ? HP_INIT_C : wide[HP_W-1:0];
    endfunction

    // -------------------------------------------------------------------------
    // Registers
    // -------------------------------------------------------------------------
    logic [3:0]      page_q,   page_d;
    logic [CNT_W-1:0] cnt_q,   cnt_d;
    logic [HP_W-1:0] mon_q,    mon_d;
    logic [HP_W-1:0] php_q,    php_d;
    logic [15:0]     instr_q,  instr_d;
    logic            move_q,   move_d;
    logic            win_q,    win_d;
    logic            lose_q,   lose_d;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            page_q  <= PAGE_MENU;
            cnt_q   <= '0;
            mon_q   <= '0;
            php_q   <= '0;
            instr_q <= '0;
            move_q  <= 1'b0;
            win_q   <= 1'b0;
            lose_q  <= 1'b0;
        end else begin
            page_q  <= page_d;
            cnt_q   <= cnt_d;
            mon_q   <= mon_d;
            php_q   <= php_d;
            instr_q <= instr_d;
            move_q  <= move_d;
            win_q   <= win_d;
            lose_q  <= lose_d;
        end
    end

    // -------------------------------------------------------------------------
    // Next-state and output logic
    // -------------------------------------------------------------------------
    move_t           mv;
    logic [HP_W-1:0] hp_hit;
    logic [HP_W-1:0] mon_sum;

    always_comb begin
        // NOTE: every variable written here gets a default first so no path
        // leaves one unassigned, which would otherwise infer a latch.
        page_d  = page_q;
        cnt_d   = cnt_q;
        mon_d   = mon_q;
        php_d   = php_q;
        instr_d = '0;
        move_d  = 1'b0;
        win_d   = 1'b0;
        lose_d  = 1'b0;
        mv      = key_to_move(keyboard);
        hp_hit  = hit ? sat_sub(php_q, hit_dmg) : php_q;
        mon_sum = sat_add(mon_q, atk_dmg);

        case (page_q)
            PAGE_MENU: begin
                if (press && keyboard == KEY_SPACE) begin
                    page_d = PAGE_DODGE;
                    mon_d  = '0;
                    php_d  = HP_INIT_C;
                    cnt_d  = '0;
                end
            end

            PAGE_DODGE: begin
                // Movement follows the held key, not the press edge.
                if (mv.valid) begin
                    instr_d = {OP_MOV, mv.dir, 8'h00};
                    move_d  = 1'b1;
                end
                // The hit lands before the tick is considered, so a fatal hit
                // on the final tick ends the game instead of reaching ACTION.
                php_d = hp_hit;
                if (hit && hp_hit == '0) begin
                    lose_d = 1'b1;
                    page_d = PAGE_MENU;
                    cnt_d  = '0;
                end else if (tick) begin
                    if (cnt_q == CNT_LAST) begin
                        page_d = PAGE_ACTION;
                        cnt_d  = '0;
                    end else begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end

            PAGE_ACTION: begin
                if (press) begin
                    case (keyboard)
                        KEY_J: page_d = PAGE_ATTACK;
                        KEY_K: begin
                            php_d  = heal(php_q);
                            page_d = PAGE_DODGE;
                        end
                        KEY_L: page_d = PAGE_MENU;
                        default: ;
                    endcase
                end
            end

            PAGE_ATTACK: begin
                if (atk_pass) begin
                    mon_d = mon_sum;
                    if (mon_sum > MON_MAX_C) begin
                        win_d  = 1'b1;
                        page_d = PAGE_MENU;
                    end else begin
                        page_d = PAGE_DODGE;
                    end
                end
            end

            default: page_d = PAGE_MENU;
        endcase
    end

    assign state        = {page_q, SUBSTAGE_0};
    assign player_instr = instr_q;
    assign is_move      = move_q;
    assign mon_hp       = mon_q;
    assign player_hp    = php_q;
    assign win          = win_q;
    assign lose         = lose_q;

endmodule

// File: tb/tb_battle_controller.sv
// -----------------------------------------------------------------------------
// tb_battle_controller
// Self-checking bench for battle_controller: a table of directed single-cycle
// vectors followed by hand-written multi-cycle sequences (dodge expiry, win,
// heal saturation, death, quit, mid-game reset).
// -----------------------------------------------------------------------------
module tb_battle_controller;

    localparam logic [3:0] K_NONE  = 4'd0;
    localparam logic [3:0] K_W     = 4'd1;
    localparam logic [3:0] K_S     = 4'd2;
    localparam logic [3:0] K_A     = 4'd3;
    localparam logic [3:0] K_D     = 4'd4;
    localparam logic [3:0] K_J     = 4'd5;
    localparam logic [3:0] K_K     = 4'd6;
    localparam logic [3:0] K_L     = 4'd7;
    localparam logic [3:0] K_SPACE = 4'd8;

    logic        clk = 1'b0;
    logic        rst_n;
    logic [3:0]  keyboard;
    logic        tick;
    logic        hit;
    logic [7:0]  hit_dmg;
    logic        atk_pass;
    logic [7:0]  atk_dmg;
    logic [7:0]  state;
    logic [15:0] player_instr;
    logic        is_move;
    logic [7:0]  mon_hp;
    logic [7:0]  player_hp;
    logic        win;
    logic        lose;

    int total = 0;
    int bad   = 0;

    battle_controller dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .keyboard     (keyboard),
        .tick         (tick),
        .hit          (hit),
        .hit_dmg      (hit_dmg),
        .atk_pass     (atk_pass),
        .atk_dmg      (atk_dmg),
        .state        (state),
        .player_instr (player_instr),
        .is_move      (is_move),
        .mon_hp       (mon_hp),
        .player_hp    (player_hp),
        .win          (win),
        .lose         (lose)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  kb;
        logic        tk;
        logic        ht;
        logic [7:0]  hd;
        logic        ap;
        logic [7:0]  ad;
        logic [7:0]  e_state;
        logic [15:0] e_instr;
        logic        e_move;
        logic [7:0]  e_mon;
        logic [7:0]  e_php;
    } vec_t;

    vec_t vecs[12];

    task automatic check(input string name, input logic [31:0] act,
                         input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    // Drive one cycle of inputs at the falling edge, sample 1ns after the rise.
    task automatic cyc(input logic [3:0] kb, input logic tk, input logic ht,
                       input logic [7:0] hd, input logic ap, input logic [7:0] ad);
        @(negedge clk);
        keyboard = kb;
        tick     = tk;
        hit      = ht;
        hit_dmg  = hd;
        atk_pass = ap;
        atk_dmg  = ad;
        @(posedge clk);
        #1;
    endtask

    task automatic idle();
        cyc(K_NONE, 1'b0, 1'b0, 8'd0, 1'b0, 8'd0);
    endtask

    // n tick pulses, each separated by an idle cycle.
    task automatic run_ticks(input int n);
        for (int i = 0; i < n; i++) begin
            idle();
            cyc(K_NONE, 1'b1, 1'b0, 8'd0, 1'b0, 8'd0);
        end
    endtask

    task automatic do_reset();
        @(negedge clk);
        rst_n    = 1'b0;
        keyboard = K_NONE;
        tick     = 1'b0;
        hit      = 1'b0;
        hit_dmg  = 8'd0;
        atk_pass = 1'b0;
        atk_dmg  = 8'd0;
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    initial begin
        // keyboard, tick, hit, hit_dmg, atk_pass, atk_dmg,
        // state, instr, is_move, mon_hp, player_hp
        vecs[0]  = '{K_NONE,  0, 0, 8'd0, 0, 8'd0,  8'h10, 16'h0000, 0, 8'd0, 8'd0};
        vecs[1]  = '{K_SPACE, 0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h0000, 0, 8'd0, 8'd20};
        vecs[2]  = '{K_SPACE, 0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h0000, 0, 8'd0, 8'd20};
        vecs[3]  = '{K_D,     0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h5100, 1, 8'd0, 8'd20};
        vecs[4]  = '{K_D,     0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h5100, 1, 8'd0, 8'd20};
        vecs[5]  = '{K_D,     0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h5100, 1, 8'd0, 8'd20};
        vecs[6]  = '{K_NONE,  0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h0000, 0, 8'd0, 8'd20};
        vecs[7]  = '{K_W,     0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h5000, 1, 8'd0, 8'd20};
        vecs[8]  = '{K_A,     0, 1, 8'd4, 0, 8'd0,  8'h90, 16'h5300, 1, 8'd0, 8'd16};
        vecs[9]  = '{K_S,     0, 1, 8'd1, 0, 8'd0,  8'h90, 16'h5200, 1, 8'd0, 8'd15};
        vecs[10] = '{K_NONE,  0, 0, 8'd0, 1, 8'd50, 8'h90, 16'h0000, 0, 8'd0, 8'd15};
        vecs[11] = '{K_J,     0, 0, 8'd0, 0, 8'd0,  8'h90, 16'h0000, 0, 8'd0, 8'd15};

        rst_n    = 1'b0;
        keyboard = K_NONE;
        tick     = 1'b0;
        hit      = 1'b0;
        hit_dmg  = 8'd0;
        atk_pass = 1'b0;
        atk_dmg  = 8'd0;
        #12;
        check("reset state",     32'(state),        32'h10);
        check("reset instr",     32'(player_instr), 32'h0);
        check("reset is_move",   32'(is_move),      32'h0);
        check("reset mon_hp",    32'(mon_hp),       32'h0);
        check("reset player_hp", 32'(player_hp),    32'h0);
        check("reset win/lose",  32'({win, lose}),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;

        // ---------------- table-driven vectors ----------------
        for (int i = 0; i < 12; i++) begin
            cyc(vecs[i].kb, vecs[i].tk, vecs[i].ht, vecs[i].hd, vecs[i].ap, vecs[i].ad);
            check($sformatf("vec%0d state", i),   32'(state),        32'(vecs[i].e_state));
            check($sformatf("vec%0d instr", i),   32'(player_instr), 32'(vecs[i].e_instr));
            check($sformatf("vec%0d is_move", i), 32'(is_move),      32'(vecs[i].e_move));
            check($sformatf("vec%0d mon_hp", i),  32'(mon_hp),       32'(vecs[i].e_mon));
            check($sformatf("vec%0d php", i),     32'(player_hp),    32'(vecs[i].e_php));
            check($sformatf("vec%0d win/lose", i), 32'({win, lose}), 32'h0);
        end

        // ---------------- dodge expiry with hit on the 60th tick ----------------
        do_reset();
        cyc(K_SPACE, 0, 0, 8'd0, 0, 8'd0);
        check("start state", 32'(state), 32'h90);
        run_ticks(59);
        check("59 ticks still dodge", 32'(state), 32'h90);
        idle();
        cyc(K_NONE, 1, 1, 8'd3, 0, 8'd0);
        check("60th tick state", 32'(state),     32'hB0);
        check("60th tick hp",    32'(player_hp), 32'd17);
        check("60th tick lose",  32'(lose),      32'h0);

        // ---------------- attack twice to victory ----------------
        cyc(K_NONE, 0, 1, 8'd9, 0, 8'd0);
        check("hit ignored in action", 32'(player_hp), 32'd17);
        cyc(K_J, 0, 0, 8'd0, 0, 8'd0);
        check("J to attack", 32'(state), 32'hA0);
        cyc(K_NONE, 0, 0, 8'd0, 1, 8'd60);
        check("atk1 mon_hp", 32'(mon_hp), 32'd60);
        check("atk1 state",  32'(state),  32'h90);
        check("atk1 no win", 32'(win),    32'h0);
        run_ticks(60);
        check("round2 action", 32'(state), 32'hB0);
        cyc(K_J, 0, 0, 8'd0, 0, 8'd0);
        check("round2 attack", 32'(state), 32'hA0);
        cyc(K_NONE, 0, 0, 8'd0, 1, 8'd60);
        check("atk2 mon_hp", 32'(mon_hp), 32'd120);
        check("atk2 win",    32'(win),    32'h1);
        check("atk2 state",  32'(state),  32'h10);
        idle();
        check("win one cycle", 32'(win),       32'h0);
        check("mon_hp holds",  32'(mon_hp),    32'd120);
        check("php holds",     32'(player_hp), 32'd17);

        // ---------------- heal saturation with K held ----------------
        cyc(K_SPACE, 0, 0, 8'd0, 0, 8'd0);
        check("restart mon_hp", 32'(mon_hp),    32'd0);
        check("restart php",    32'(player_hp), 32'd20);
        cyc(K_NONE, 0, 1, 8'd2, 0, 8'd0);
        check("hp 18", 32'(player_hp), 32'd18);
        run_ticks(60);
        check("heal action", 32'(state), 32'hB0);
        for (int i = 0; i < 4; i++) begin
            cyc(K_K, 0, 0, 8'd0, 0, 8'd0);
            check($sformatf("heal hold%0d hp", i),    32'(player_hp), 32'd20);
            check($sformatf("heal hold%0d state", i), 32'(state),     32'h90);
        end
        idle();

        // ---------------- death by saturating hit ----------------
        cyc(K_NONE, 0, 1, 8'd18, 0, 8'd0);
        check("hp 2", 32'(player_hp), 32'd2);
        cyc(K_NONE, 0, 1, 8'd5, 0, 8'd0);
        check("death hp",    32'(player_hp), 32'd0);
        check("death lose",  32'(lose),      32'h1);
        check("death state", 32'(state),     32'h10);
        idle();
        check("lose one cycle", 32'(lose),      32'h0);
        check("dead hp holds",  32'(player_hp), 32'd0);

        // ---------------- quit from ACTION ----------------
        cyc(K_SPACE, 0, 0, 8'd0, 0, 8'd0);
        run_ticks(60);
        cyc(K_L, 0, 0, 8'd0, 0, 8'd0);
        check("L to menu",    32'(state),        32'h10);
        check("L no pulse",   32'({win, lose}),  32'h0);
        check("L php holds",  32'(player_hp),    32'd20);

        // ---------------- fatal hit on the final tick ----------------
        cyc(K_SPACE, 0, 0, 8'd0, 0, 8'd0);
        cyc(K_NONE, 0, 1, 8'd18, 0, 8'd0);
        run_ticks(59);
        idle();
        cyc(K_NONE, 1, 1, 8'd5, 0, 8'd0);
        check("death over action state", 32'(state), 32'h10);
        check("death over action lose",  32'(lose),  32'h1);

        // ---------------- asynchronous reset mid-game ----------------
        idle();
        cyc(K_SPACE, 0, 0, 8'd0, 0, 8'd0);
        cyc(K_D, 0, 1, 8'd4, 0, 8'd0);
        check("pre-reset hp", 32'(player_hp), 32'd16);
        @(negedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        check("async reset state", 32'(state),        32'h10);
        check("async reset instr", 32'(player_instr), 32'h0);
        check("async reset hp",    32'(player_hp),    32'h0);
        check("async reset pulse", 32'({win, lose}),  32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        idle();
        check("after reset state", 32'(state),       32'h10);
        check("after reset pulse", 32'({win, lose}), 32'h0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
